// File: rtl/ex_hazard_sequencer_if.sv
// Hazard/sequencing bundle between the pipeline datapath and the hazard sequencer.
// master: pipeline side (drives register ids and stage flags, receives controls).
// slave:  hazard sequencer side.
interface ex_hazard_sequencer_if #(
   parameter int unsigned CNT_WIDTH = 16
);
   logic [4:0]           rs1_D;
   logic [4:0]           rs2_D;
   logic [4:0]           rs1_E;
   logic [4:0]           rs2_E;
   logic [4:0]           rd_E;
   logic [4:0]           rd_M;
   logic [4:0]           rd_W;
   logic                 RegWrite_M;
   logic                 RegWrite_W;
   logic                 MemRead_E;
   logic                 PCSrc_E;
   logic                 MultiCycle_E;
   logic [1:0]           ForwardA_E;
   logic [1:0]           ForwardB_E;
   logic                 Stall_F;
   logic                 Stall_D;
   logic                 Stall_E;
   logic                 Flush_D;
   logic                 Flush_E;
   logic                 Bubble_M;
   logic                 mc_busy;
   logic                 mc_done;
   logic [CNT_WIDTH-1:0] stall_cnt;

   modport master (
      output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
      output RegWrite_M, RegWrite_W, MemRead_E, PCSrc_E, MultiCycle_E,
      input  ForwardA_E, ForwardB_E, Stall_F, Stall_D, Stall_E,
      input  Flush_D, Flush_E, Bubble_M, mc_busy, mc_done, stall_cnt
   );

   modport slave (
      input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
      input  RegWrite_M, RegWrite_W, MemRead_E, PCSrc_E, MultiCycle_E,
      output ForwardA_E, ForwardB_E, Stall_F, Stall_D, Stall_E,
      output Flush_D, Flush_E, Bubble_M, mc_busy, mc_done, stall_cnt
   );
endinterface

// File: rtl/ex_hazard_sequencer.sv
// Hazard and sequencing controller for the 5-stage pipeline: execute-stage forwarding
// selects, load-use and taken-branch handling, a multi-cycle execute hold FSM and a
// saturating stall-cycle counter.
module ex_hazard_sequencer #(
   parameter int unsigned MC_LATENCY = 8,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   ex_hazard_sequencer_if.slave hz
);

   localparam int unsigned McCntW = $clog2(MC_LATENCY);
   localparam logic [McCntW-1:0] McLoad = McCntW'(MC_LATENCY - 2);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} mc_state_e;

   mc_state_e            state_q, state_d;
   logic [McCntW-1:0]    cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

   logic       mc_busy, mc_done, lu, br;
   logic [1:0] fwd_a, fwd_b;
   logic       stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m;

   // Memory stage wins over writeback; x0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                          input logic wr_m, input logic [4:0] rd_w,
                                          input logic wr_w);
      if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) return 2'b10;
      if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) return 2'b01;
      return 2'b00;
   endfunction

   // FSM state, occupancy counter and stall counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Multi-cycle FSM next state; mc_busy covers the detect cycle and every BUSY cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mc_busy = 1'b0;
      mc_done = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (hz.MultiCycle_E) begin
               mc_busy = 1'b1;
               if (MC_LATENCY > 2) begin
                  state_d = StBusy;
                  cnt_d   = McLoad;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StBusy: begin
            mc_busy = 1'b1;
            cnt_d   = cnt_q - McCntW'(1);
            // Leave once the counter would reach zero, giving MC_LATENCY-2 BUSY cycles.
            if (cnt_q == McCntW'(1)) state_d = StDone;
         end
         StDone: begin
            // MultiCycle_E here still belongs to the finishing op.
            mc_done = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Hazard controls; outputs are forced quiet while reset is held.
   always_comb begin
      lu       = hz.MemRead_E && (hz.rd_E != 5'd0) &&
                 ((hz.rd_E == hz.rs1_D) || (hz.rd_E == hz.rs2_D));
      br       = hz.PCSrc_E;
      fwd_a    = fwd_sel(hz.rs1_E, hz.rd_M, hz.RegWrite_M, hz.rd_W, hz.RegWrite_W);
      fwd_b    = fwd_sel(hz.rs2_E, hz.rd_M, hz.RegWrite_M, hz.rd_W, hz.RegWrite_W);
      stall_f  = 1'b0;
      stall_d  = 1'b0;
      stall_e  = 1'b0;
      flush_d  = 1'b0;
      flush_e  = 1'b0;
      bubble_m = 1'b0;
      if (mc_busy) begin
         // The multi-cycle op owns E; decode hazards wait until it releases.
         stall_f  = 1'b1;
         stall_d  = 1'b1;
         stall_e  = 1'b1;
         bubble_m = 1'b1;
      end else begin
         stall_f = lu && !br;
         stall_d = lu && !br;
         flush_d = br;
         flush_e = br || lu;
      end
      if (!rst_n) begin
         fwd_a    = 2'b00;
         fwd_b    = 2'b00;
         stall_f  = 1'b0;
         stall_d  = 1'b0;
         stall_e  = 1'b0;
         flush_d  = 1'b0;
         flush_e  = 1'b0;
         bubble_m = 1'b0;
      end
   end

   // Saturating count of PC-hold cycles.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_f && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
   end

   assign hz.ForwardA_E = fwd_a;
   assign hz.ForwardB_E = fwd_b;
   assign hz.Stall_F    = stall_f;
   assign hz.Stall_D    = stall_d;
   assign hz.Stall_E    = stall_e;
   assign hz.Flush_D    = flush_d;
   assign hz.Flush_E    = flush_e;
   assign hz.Bubble_M   = bubble_m;
   assign hz.mc_busy    = mc_busy && rst_n;
   assign hz.mc_done    = mc_done && rst_n;
   assign hz.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_ex_hazard_sequencer.sv
// Bench for ex_hazard_sequencer: directed table, multi-cycle/reset/saturation sequences,
// and random stimulus against an occupancy-based reference model.
module tb_ex_hazard_sequencer;

   localparam int unsigned L = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ex_hazard_sequencer_if #(.CNT_WIDTH(16)) hif ();
   ex_hazard_sequencer_if #(.CNT_WIDTH(4))  hif4 ();

   // Second instance sees identical stimulus; only its counter width differs.
   assign hif4.rs1_D        = hif.rs1_D;
   assign hif4.rs2_D        = hif.rs2_D;
   assign hif4.rs1_E        = hif.rs1_E;
   assign hif4.rs2_E        = hif.rs2_E;
   assign hif4.rd_E         = hif.rd_E;
   assign hif4.rd_M         = hif.rd_M;
   assign hif4.rd_W         = hif.rd_W;
   assign hif4.RegWrite_M   = hif.RegWrite_M;
   assign hif4.RegWrite_W   = hif.RegWrite_W;
   assign hif4.MemRead_E    = hif.MemRead_E;
   assign hif4.PCSrc_E      = hif.PCSrc_E;
   assign hif4.MultiCycle_E = hif.MultiCycle_E;

   ex_hazard_sequencer #(.MC_LATENCY(L), .CNT_WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hif.slave)
   );

   ex_hazard_sequencer #(.MC_LATENCY(L), .CNT_WIDTH(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hif4.slave)
   );

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // {fa[1:0], fb[1:0], sf, sd, se, fd, fe, bm, busy, done}
   function automatic logic [11:0] ctl();
      return {hif.ForwardA_E, hif.ForwardB_E, hif.Stall_F, hif.Stall_D, hif.Stall_E,
              hif.Flush_D, hif.Flush_E, hif.Bubble_M, hif.mc_busy, hif.mc_done};
   endfunction

   localparam logic [11:0] CtlBusy = 12'b0000_1110_0110;
   localparam logic [11:0] CtlDone = 12'b0000_0000_0001;

   task automatic clear_inputs();
      hif.rs1_D = '0; hif.rs2_D = '0; hif.rs1_E = '0; hif.rs2_E = '0;
      hif.rd_E = '0; hif.rd_M = '0; hif.rd_W = '0;
      hif.RegWrite_M = 0; hif.RegWrite_W = 0; hif.MemRead_E = 0;
      hif.PCSrc_E = 0; hif.MultiCycle_E = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
      logic       rw_m, rw_w, mr_e, pc_e;
      logic [11:0] exp_ctl;
   } vec_t;

   vec_t vecs[9];

   // Reference model state: position of the multi-cycle op inside its E occupancy.
   int age;
   int exp_cnt;
   int exp_cnt4;

   initial begin
      // fa fb  sf sd se fd fe bm busy done
      vecs[0] = '{5'd1, 5'd2, 5'd5, 5'd3, 5'd9, 5'd5, 5'd5, 1, 1, 0, 0, 12'b10_00_0000_0000};
      vecs[1] = '{5'd1, 5'd2, 5'd5, 5'd3, 5'd9, 5'd5, 5'd5, 0, 1, 0, 0, 12'b01_00_0000_0000};
      vecs[2] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 12'b00_00_0000_0000};
      vecs[3] = '{5'd1, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 1, 0, 12'b00_00_1100_1000};
      vecs[4] = '{5'd1, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 1, 1, 12'b00_00_0001_1000};
      vecs[5] = '{5'd3, 5'd4, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 0, 0, 0, 1, 12'b00_00_0001_1000};
      vecs[6] = '{5'd0, 5'd0, 5'd4, 5'd6, 5'd0, 5'd6, 5'd4, 1, 1, 0, 0, 12'b01_10_0000_0000};
      vecs[7] = '{5'd12, 5'd1, 5'd8, 5'd0, 5'd12, 5'd0, 5'd8, 0, 0, 1, 0, 12'b00_00_1100_1000};
      vecs[8] = '{5'd1, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 0, 0, 12'b00_00_0000_0000};

      // Reset state, with hazards present on the inputs.
      clear_inputs();
      hif.MemRead_E = 1; hif.rd_E = 5'd7; hif.rs2_D = 5'd7;
      hif.RegWrite_M = 1; hif.rd_M = 5'd3; hif.rs1_E = 5'd3; hif.MultiCycle_E = 1;
      #1;
      check("reset_ctl", 32'(ctl()), 32'd0);
      check("reset_cnt", 32'(hif.stall_cnt), 32'd0);
      @(negedge clk);
      clear_inputs();
      rst_n = 1'b1;

      // Single load-use cycle.
      @(negedge clk);
      hif.MemRead_E = 1; hif.rd_E = 5'd7; hif.rs2_D = 5'd7;
      #1 check("lu_ctl", 32'(ctl()), 32'(12'b00_00_1100_1000));
      @(negedge clk);
      clear_inputs();
      #1 check("lu_release_ctl", 32'(ctl()), 32'd0);
      check("lu_cnt", 32'(hif.stall_cnt), 32'd1);

      // Multi-cycle op, MultiCycle_E held through the occupancy.
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         hif.MultiCycle_E = (c <= 8);
         #1;
         if (c <= 7) check($sformatf("mc_busy_c%0d", c), 32'(ctl()), 32'(CtlBusy));
         else if (c == 8) check("mc_done_c8", 32'(ctl()), 32'(CtlDone));
         else check("mc_idle_c9", 32'(ctl()), 32'd0);
      end
      check("mc_cnt", 32'(hif.stall_cnt), 32'd8);

      // Directed combinational table.
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         hif.rs1_D = vecs[i].rs1_d; hif.rs2_D = vecs[i].rs2_d;
         hif.rs1_E = vecs[i].rs1_e; hif.rs2_E = vecs[i].rs2_e;
         hif.rd_E = vecs[i].rd_e; hif.rd_M = vecs[i].rd_m; hif.rd_W = vecs[i].rd_w;
         hif.RegWrite_M = vecs[i].rw_m; hif.RegWrite_W = vecs[i].rw_w;
         hif.MemRead_E = vecs[i].mr_e; hif.PCSrc_E = vecs[i].pc_e;
         hif.MultiCycle_E = 0;
         #1 check($sformatf("vec%0d", i), 32'(ctl()), 32'(vecs[i].exp_ctl));
      end
      @(negedge clk);
      clear_inputs();
      #1 check("table_cnt", 32'(hif.stall_cnt), 32'd10);

      // Reset during the 4th BUSY cycle.
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         hif.MultiCycle_E = 1;
      end
      #1 check("rst_mid_pre", 32'(ctl()), 32'(CtlBusy));
      rst_n = 1'b0;
      #1 check("rst_mid_ctl", 32'(ctl()), 32'd0);
      check("rst_mid_cnt", 32'(hif.stall_cnt), 32'd0);
      hif.MultiCycle_E = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #1 check($sformatf("post_rst_idle%0d", c), 32'(ctl()), 32'd0);
      end

      // Counter saturation on the 4-bit instance.
      do_reset();
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         hif.MemRead_E = 1; hif.rd_E = 5'd9; hif.rs1_D = 5'd9;
      end
      @(negedge clk);
      clear_inputs();
      #1 check("sat_cnt4", 32'(hif4.stall_cnt), 32'd15);
      check("sat_cnt16", 32'(hif.stall_cnt), 32'd20);

      // Random stimulus against the reference model.
      do_reset();
      age = 0; exp_cnt = 0; exp_cnt4 = 0;
      for (int n = 0; n < 2000; n++) begin
         logic [1:0]  e_fa, e_fb;
         logic        e_lu, e_busy, e_done, e_sf, e_fd, e_fe;
         logic [11:0] e_ctl;
         int          cur;
         @(negedge clk);
         hif.rs1_D = 5'($urandom_range(0, 3)); hif.rs2_D = 5'($urandom_range(0, 3));
         hif.rs1_E = 5'($urandom_range(0, 3)); hif.rs2_E = 5'($urandom_range(0, 3));
         hif.rd_E = 5'($urandom_range(0, 3)); hif.rd_M = 5'($urandom_range(0, 3));
         hif.rd_W = 5'($urandom_range(0, 3));
         hif.RegWrite_M = 1'($urandom); hif.RegWrite_W = 1'($urandom);
         hif.MemRead_E = 1'($urandom); hif.PCSrc_E = ($urandom_range(0, 3) == 0);
         hif.MultiCycle_E = ($urandom_range(0, 9) == 0);
         #1;
         e_fa = (hif.RegWrite_M && hif.rd_M != 0 && hif.rd_M == hif.rs1_E) ? 2'b10 :
                (hif.RegWrite_W && hif.rd_W != 0 && hif.rd_W == hif.rs1_E) ? 2'b01 : 2'b00;
         e_fb = (hif.RegWrite_M && hif.rd_M != 0 && hif.rd_M == hif.rs2_E) ? 2'b10 :
                (hif.RegWrite_W && hif.rd_W != 0 && hif.rd_W == hif.rs2_E) ? 2'b01 : 2'b00;
         cur = age;
         if (cur == 0 && hif.MultiCycle_E) cur = 1;
         e_busy = (cur >= 1) && (cur <= int'(L) - 1);
         e_done = (cur == int'(L));
         e_lu = hif.MemRead_E && hif.rd_E != 0 &&
                (hif.rd_E == hif.rs1_D || hif.rd_E == hif.rs2_D);
         if (e_busy) begin
            e_ctl = {e_fa, e_fb, 8'b1110_0110};
            e_sf = 1;
         end else begin
            e_sf = e_lu && !hif.PCSrc_E;
            e_fd = hif.PCSrc_E;
            e_fe = hif.PCSrc_E || e_lu;
            e_ctl = {e_fa, e_fb, e_sf, e_sf, 1'b0, e_fd, e_fe, 1'b0, 1'b0, e_done};
         end
         check($sformatf("rnd%0d_ctl", n), 32'(ctl()), 32'(e_ctl));
         check($sformatf("rnd%0d_cnt", n), 32'(hif.stall_cnt), 32'(exp_cnt));
         check($sformatf("rnd%0d_cnt4", n), 32'(hif4.stall_cnt), 32'(exp_cnt4));
         if (e_sf) begin
            if (exp_cnt < 65535) exp_cnt++;
            if (exp_cnt4 < 15) exp_cnt4++;
         end
         age = (cur > 0 && cur < int'(L)) ? cur + 1 : 0;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
